// File: rtl/rtype_sequencer.sv
// Purpose: R-type sub-FSM for the multicycle MIPS control; decodes Funct and sequences EXEC/WB.
// Latency: ALU op Done 2 cycles after Start; NOP/illegal Done 1 cycle after; BREAK Done 1 cycle after Resume.
// Backpressure: Start is accepted only in IDLE; Start while Busy (including the Done cycle) is dropped.
//
// Ports:
//   Clk, Reset          clock (posedge) and asynchronous active-low reset
//   Start, Funct        accept pulse from main control in DECODE and the IR[5:0] funct field
//   Resume              releases a BREAK halt (sampled only while halted)
//   NextFunctState      combinational decode of Funct into the main-control R-type state code
//   Busy, Done, Halted  sequencing status; Done is a 1-cycle completion pulse
//   ALUFunct, ALUSrcA, ALUSrcB, ALUOut_load, RegDst, MemtoReg, RegWrite   datapath controls
//   IllegalFunct        sticky unsupported-funct flag, cleared by the next accepted Start
module rtype_sequencer #(
    parameter int                   STATE_W       = 8,
    parameter logic [STATE_W-1:0]   ST_RTYPE_BASE = STATE_W'(8'h10)
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic [5:0]         Funct,
    input  logic               Resume,
    output logic [STATE_W-1:0] NextFunctState,
    output logic               Busy,
    output logic               Done,
    output logic [2:0]         ALUFunct,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic               ALUOut_load,
    output logic               RegDst,
    output logic               MemtoReg,
    output logic               RegWrite,
    output logic               Halted,
    output logic               IllegalFunct
);

    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_XOR = 6'h26;
    localparam logic [5:0] F_NOP = 6'h00;
    localparam logic [5:0] F_BRK = 6'h0D;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_EXEC = 3'd1,
        S_WB   = 3'd2,
        S_BRK  = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [5:0] funct_q;
    logic [2:0] funct_idx;
    logic       start_acc;

    // Decode index: 0..3 ALU ops, 4 NOP, 5 BREAK, 6 illegal.
    always_comb begin
        funct_idx = 3'd6;
        case (Funct)
            F_ADD:   funct_idx = 3'd0;
            F_SUB:   funct_idx = 3'd1;
            F_AND:   funct_idx = 3'd2;
            F_XOR:   funct_idx = 3'd3;
            F_NOP:   funct_idx = 3'd4;
            F_BRK:   funct_idx = 3'd5;
            default: funct_idx = 3'd6;
        endcase
    end

    assign NextFunctState = ST_RTYPE_BASE + STATE_W'(funct_idx);

    // Only IDLE accepts work, which also drops a Start coinciding with Done.
    assign start_acc = Start && (state == S_IDLE);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            funct_q      <= 6'h00;
            IllegalFunct <= 1'b0;
        end else if (start_acc) begin
            funct_q      <= Funct;
            IllegalFunct <= (funct_idx == 3'd6);
        end
    end

    always_comb begin
        state_nxt   = state;
        Busy        = (state != S_IDLE);
        Done        = 1'b0;
        ALUFunct    = 3'b000;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOut_load = 1'b0;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        Halted      = 1'b0;

        case (state)
            S_IDLE: begin
                if (start_acc) begin
                    if (funct_idx <= 3'd3)       state_nxt = S_EXEC;
                    else if (funct_idx == 3'd5)  state_nxt = S_BRK;
                    else                         state_nxt = S_FIN;
                end
            end
            S_EXEC: begin
                ALUSrcA     = 1'b1;
                ALUSrcB     = 2'b00;
                ALUOut_load = 1'b1;
                case (funct_q)
                    F_ADD:   ALUFunct = 3'b001;
                    F_SUB:   ALUFunct = 3'b010;
                    F_AND:   ALUFunct = 3'b011;
                    F_XOR:   ALUFunct = 3'b110;
                    default: ALUFunct = 3'b000;
                endcase
                state_nxt = S_WB;
            end
            S_WB: begin
                RegDst    = 1'b1;
                MemtoReg  = 1'b0;
                RegWrite  = 1'b1;
                Done      = 1'b1;
                state_nxt = S_IDLE;
            end
            S_BRK: begin
                Halted = 1'b1;
                if (Resume) state_nxt = S_FIN;
            end
            S_FIN: begin
                Done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_rtype_sequencer.sv
// Purpose: self-checking bench for rtype_sequencer with a completion scoreboard.
// Latency: inputs driven 1ns after posedge, outputs sampled 1ns after posedge or at negedge.
// Backpressure: exercises Start while Busy and Start in the Done cycle.
module tb_rtype_sequencer;

    logic       Clk;
    logic       Reset;
    logic       Start;
    logic [5:0] Funct;
    logic       Resume;
    logic [7:0] NextFunctState;
    logic       Busy;
    logic       Done;
    logic [2:0] ALUFunct;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       ALUOut_load;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       Halted;
    logic       IllegalFunct;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0] alu;
        logic       wr;
    } exp_t;

    exp_t       sb_q[$];
    logic [2:0] alu_seen;

    rtype_sequencer #(.STATE_W(8), .ST_RTYPE_BASE(8'h10)) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .Start          (Start),
        .Funct          (Funct),
        .Resume         (Resume),
        .NextFunctState (NextFunctState),
        .Busy           (Busy),
        .Done           (Done),
        .ALUFunct       (ALUFunct),
        .ALUSrcA        (ALUSrcA),
        .ALUSrcB        (ALUSrcB),
        .ALUOut_load    (ALUOut_load),
        .RegDst         (RegDst),
        .MemtoReg       (MemtoReg),
        .RegWrite       (RegWrite),
        .Halted         (Halted),
        .IllegalFunct   (IllegalFunct)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Completion monitor: each Done pops one expected record.
    always @(negedge Clk) begin
        if (!Reset) begin
            alu_seen = 3'b000;
        end else begin
            if (ALUOut_load) alu_seen = ALUFunct;
            if (Done) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_done: Done=%b with no outstanding op", Done);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    if (RegWrite !== e.wr || alu_seen !== e.alu) begin
                        errors++;
                        $display("FAIL sb_done: got wr=%b alu=%b, expected wr=%b alu=%b",
                                 RegWrite, alu_seen, e.wr, e.alu);
                    end
                end
                alu_seen = 3'b000;
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] f);
        Start = 1'b1;
        Funct = f;
        tick();
        Start = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b0; Start = 1'b0; Funct = 6'h00; Resume = 1'b0;
        tick();
        checks++;
        if ({Busy, Done, ALUFunct, ALUSrcA, ALUSrcB, ALUOut_load, RegDst, MemtoReg,
             RegWrite, Halted, IllegalFunct} !== 14'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, expected all zero",
                     {Busy, Done, ALUFunct, ALUSrcA, ALUSrcB, ALUOut_load, RegDst, MemtoReg,
                      RegWrite, Halted, IllegalFunct});
        end
        Reset = 1'b1;
        tick();
        checks++;
        if (Busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: Busy=%b expected 0", Busy);
        end
    endtask

    task automatic test_decode();
        logic [5:0] f_tab [8] = '{6'h20, 6'h22, 6'h24, 6'h26, 6'h00, 6'h0D, 6'h3F, 6'h01};
        logic [7:0] e_tab [8] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h16};
        for (int i = 0; i < 8; i++) begin
            Funct = f_tab[i];
            #1;
            checks++;
            if (NextFunctState !== e_tab[i]) begin
                errors++;
                $display("FAIL decode_%0h: got %h expected %h", f_tab[i], NextFunctState, e_tab[i]);
            end
        end
        tick();
    endtask

    task automatic test_add();
        sb_q.push_back('{alu: 3'b001, wr: 1'b1});
        issue(6'h20);
        checks++;
        if (ALUFunct !== 3'b001 || ALUOut_load !== 1'b1 || ALUSrcA !== 1'b1 ||
            ALUSrcB !== 2'b00 || Busy !== 1'b1 || RegWrite !== 1'b0 || Done !== 1'b0) begin
            errors++;
            $display("FAIL add_exec: alu=%b load=%b srca=%b srcb=%b busy=%b wr=%b done=%b",
                     ALUFunct, ALUOut_load, ALUSrcA, ALUSrcB, Busy, RegWrite, Done);
        end
        tick();
        checks++;
        if (RegWrite !== 1'b1 || RegDst !== 1'b1 || Done !== 1'b1 || MemtoReg !== 1'b0 ||
            ALUFunct !== 3'b000 || ALUOut_load !== 1'b0) begin
            errors++;
            $display("FAIL add_wb: wr=%b dst=%b done=%b m2r=%b alu=%b load=%b",
                     RegWrite, RegDst, Done, MemtoReg, ALUFunct, ALUOut_load);
        end
        tick();
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0) begin
            errors++;
            $display("FAIL add_idle: busy=%b done=%b expected 0 0", Busy, Done);
        end
    endtask

    task automatic test_nop();
        sb_q.push_back('{alu: 3'b000, wr: 1'b0});
        issue(6'h00);
        checks++;
        if (Done !== 1'b1 || RegWrite !== 1'b0 || IllegalFunct !== 1'b0) begin
            errors++;
            $display("FAIL nop_fin: done=%b wr=%b illegal=%b expected 1 0 0", Done, RegWrite, IllegalFunct);
        end
        tick();
    endtask

    task automatic test_break();
        int bad = 0;
        sb_q.push_back('{alu: 3'b000, wr: 1'b0});
        issue(6'h0D);
        for (int i = 0; i < 10; i++) begin
            if (Halted !== 1'b1 || Done !== 1'b0 || RegWrite !== 1'b0 || Busy !== 1'b1) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL brk_hold: %0d bad cycles of 10, expected 0", bad);
        end
        Resume = 1'b1;
        tick();
        Resume = 1'b0;
        checks++;
        if (Done !== 1'b1 || Halted !== 1'b0 || RegWrite !== 1'b0) begin
            errors++;
            $display("FAIL brk_resume: done=%b halted=%b wr=%b expected 1 0 0", Done, Halted, RegWrite);
        end
        tick();
        checks++;
        if (Busy !== 1'b0) begin
            errors++;
            $display("FAIL brk_idle: busy=%b expected 0", Busy);
        end
        // Resume outside BRK must not disturb IDLE.
        Resume = 1'b1;
        tick();
        Resume = 1'b0;
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0) begin
            errors++;
            $display("FAIL resume_idle: busy=%b done=%b expected 0 0", Busy, Done);
        end
    endtask

    task automatic test_illegal();
        sb_q.push_back('{alu: 3'b000, wr: 1'b0});
        issue(6'h3F);
        checks++;
        if (Done !== 1'b1 || IllegalFunct !== 1'b1 || RegWrite !== 1'b0) begin
            errors++;
            $display("FAIL illegal_fin: done=%b illegal=%b wr=%b expected 1 1 0", Done, IllegalFunct, RegWrite);
        end
        tick(); tick(); tick();
        checks++;
        if (IllegalFunct !== 1'b1 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL illegal_sticky: illegal=%b busy=%b expected 1 0", IllegalFunct, Busy);
        end
        sb_q.push_back('{alu: 3'b011, wr: 1'b1});
        issue(6'h24);
        checks++;
        if (IllegalFunct !== 1'b0 || ALUFunct !== 3'b011) begin
            errors++;
            $display("FAIL illegal_clear: illegal=%b alu=%b expected 0 011", IllegalFunct, ALUFunct);
        end
        tick(); tick();
    endtask

    task automatic test_back_to_back();
        sb_q.push_back('{alu: 3'b010, wr: 1'b1});
        issue(6'h22);
        // Start during EXEC with a different funct: ignored.
        Start = 1'b1;
        Funct = 6'h26;
        tick();
        checks++;
        if (Done !== 1'b1 || RegWrite !== 1'b1) begin
            errors++;
            $display("FAIL b2b_wb: done=%b wr=%b expected 1 1", Done, RegWrite);
        end
        // Start still high in the Done cycle: also ignored.
        tick();
        Start = 1'b0;
        checks++;
        if (Busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: busy=%b expected 0", Busy);
        end
        tick(); tick();
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_no_extra: busy=%b done=%b expected 0 0", Busy, Done);
        end
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        issue(6'h20);
        Reset = 1'b0;
        #1;
        checks++;
        if (ALUFunct !== 3'b000 || ALUOut_load !== 1'b0 || Busy !== 1'b0 || ALUSrcA !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_outputs: alu=%b load=%b busy=%b srca=%b expected 0",
                     ALUFunct, ALUOut_load, Busy, ALUSrcA);
        end
        tick();
        Reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (Done !== 1'b0 || RegWrite !== 1'b0 || Busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_mid_abort: %0d bad cycles of 4, expected 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_add();
        test_nop();
        test_break();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        tick();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d ops outstanding, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
